// File: rtl/i2c_scl_gen.sv
// Open-drain SCL generator built from four programmable quarter-periods, with slave
// clock stretching, stretch timeout and single-cycle phase strobes for the I2C master.
module i2c_scl_gen #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 250,
    parameter int TO_W        = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_q,
    input  logic [TO_W-1:0]  to_cycles,
    input  logic             scl_in,
    output logic             scl_oe,
    output logic             tick_low_mid,
    output logic             tick_rise,
    output logic             tick_high_mid,
    output logic             tick_fall,
    output logic             stretching,
    output logic             timeout,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_Q0   = 3'd1,
        S_Q1   = 3'd2,
        S_Q2   = 3'd3,
        S_Q3   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] qcnt_q, qcnt_d;
    logic [CNT_W-1:0] div_lat_q, div_lat_d;
    logic [CNT_W-1:0] div_new;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic             risen_q, risen_d;
    logic             sync1_q, scl_s_q;
    logic             low_mid_q, low_mid_d;
    logic             high_mid_q, high_mid_d;
    logic             fall_q, fall_d;
    logic             q_end;
    logic             stretch_c;
    logic             to_hit;

    // risen_q remembers that SCL was seen high in this Q2, so later dips are not a new stretch.
    assign div_new   = (div_q == '0) ? CNT_W'(1) : div_q;
    assign q_end     = (qcnt_q == '0);
    assign stretch_c = (state_q == S_Q2) && !risen_q && !scl_s_q;
    assign to_hit    = (to_cycles != '0) &&
                       (({1'b0, tcnt_q} + 1'b1) == {1'b0, to_cycles});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            qcnt_q     <= '0;
            div_lat_q  <= CNT_W'(DEFAULT_DIV);
            tcnt_q     <= '0;
            risen_q    <= 1'b0;
            sync1_q    <= 1'b1;
            scl_s_q    <= 1'b1;
            low_mid_q  <= 1'b0;
            high_mid_q <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            div_lat_q  <= div_lat_d;
            tcnt_q     <= tcnt_d;
            risen_q    <= risen_d;
            sync1_q    <= scl_in;
            scl_s_q    <= sync1_q;
            low_mid_q  <= low_mid_d;
            high_mid_q <= high_mid_d;
            fall_q     <= fall_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        qcnt_d     = q_end ? qcnt_q : qcnt_q - 1'b1;
        div_lat_d  = div_lat_q;
        tcnt_d     = '0;
        risen_d    = risen_q;
        low_mid_d  = 1'b0;
        high_mid_d = 1'b0;
        fall_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                qcnt_d  = '0;
                risen_d = 1'b0;
                if (en) begin
                    state_d   = S_Q0;
                    div_lat_d = div_new;
                    qcnt_d    = div_new - 1'b1;
                end
            end
            S_Q0: begin
                if (q_end) begin
                    state_d   = S_Q1;
                    qcnt_d    = div_lat_q - 1'b1;
                    low_mid_d = 1'b1;
                end
            end
            S_Q1: begin
                if (q_end) begin
                    state_d = S_Q2;
                    qcnt_d  = div_lat_q - 1'b1;
                    risen_d = 1'b0;
                end
            end
            S_Q2: begin
                if (stretch_c) begin
                    qcnt_d = qcnt_q;
                    tcnt_d = tcnt_q + 1'b1;
                    if (to_hit) begin
                        state_d = S_IDLE;
                        qcnt_d  = '0;
                        tcnt_d  = '0;
                    end
                end else begin
                    risen_d = 1'b1;
                    if (q_end) begin
                        state_d    = S_Q3;
                        qcnt_d     = div_lat_q - 1'b1;
                        risen_d    = 1'b0;
                        high_mid_d = 1'b1;
                    end
                end
            end
            S_Q3: begin
                // SCL dips here belong to another master and are deliberately ignored.
                if (q_end) begin
                    if (en) begin
                        state_d   = S_Q0;
                        div_lat_d = div_new;
                        qcnt_d    = div_new - 1'b1;
                        fall_d    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        qcnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                qcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        scl_oe        = (state_q == S_Q0) || (state_q == S_Q1);
        tick_low_mid  = low_mid_q;
        tick_rise     = (state_q == S_Q2) && !risen_q && scl_s_q;
        tick_high_mid = high_mid_q;
        tick_fall     = fall_q;
        stretching    = stretch_c;
        timeout       = stretch_c && to_hit;
        busy          = (state_q != S_IDLE);
        dbg_state     = state_q;
    end

endmodule
